asip_reg_bank: RTL and testbench

Parametrised multi-register bank for the max/min/avg ASIP datapath, the next generation of the single 8-bit load register. It holds DEPTH general registers of DATA_W bits, provides one write/modify port with load, increment, decrement and clear operations (for operand, accumulator and loop-counter use), and two independent registered read ports with write-first forwarding. It sits between the controller/ALU and the operand muxes.

---
 rtl/asip_reg_bank.sv | 127 ++++++++++++
 tb/tb_asip_reg_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/asip_reg_bank.sv
// Register bank for the max/min/avg ASIP datapath. It has one write/modify port
// (load/inc/dec/clear) and two registered read ports that forward a same-edge write.
module asip_reg_bank #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              Wr_en,
    input  logic [1:0]        Op,
    input  logic [ADDR_W-1:0] Wr_addr,
    input  logic [DATA_W-1:0] Wr_data,
    input  logic              Rd_en_a,
    input  logic [ADDR_W-1:0] Rd_addr_a,
    input  logic              Rd_en_b,
    input  logic [ADDR_W-1:0] Rd_addr_b,
    output logic [DATA_W-1:0] Rd_data_a,
    output logic [DATA_W-1:0] Rd_data_b,
    output logic              Zero_a,
    output logic              Zero_b,
    output logic              Wrap,
    output logic              Addr_err
);

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    // One extra bit so DEPTH itself (up to 256) is representable for the range compare.
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DATA_W-1:0] rd_data_a_q, rd_data_a_d;
    logic [DATA_W-1:0] rd_data_b_q, rd_data_b_d;
    logic              zero_a_q, zero_a_d;
    logic              zero_b_q, zero_b_d;
    logic              wrap_q, wrap_d;
    logic              addr_err_q, addr_err_d;

    logic              wr_in, rd_in_a, rd_in_b, wr_ok;
    logic [DATA_W-1:0] cur_val, new_val;

    always_comb begin
        wr_in   = ({1'b0, Wr_addr} < DEPTH_L);
        rd_in_a = ({1'b0, Rd_addr_a} < DEPTH_L);
        rd_in_b = ({1'b0, Rd_addr_b} < DEPTH_L);
        wr_ok   = Wr_en & wr_in;

        cur_val = '0;
        if (wr_ok) begin
            cur_val = regs_q[Wr_addr];
        end

        new_val = cur_val;
        wrap_d  = 1'b0;
        case (op_e'(Op))
            OP_LOAD: new_val = Wr_data;
            OP_INC: begin
                new_val = cur_val + DATA_W'(1);
                wrap_d  = wr_ok & (cur_val == '1);
            end
            OP_DEC: begin
                new_val = cur_val - DATA_W'(1);
                wrap_d  = wr_ok & (cur_val == '0);
            end
            OP_CLR:  new_val = '0;
            default: new_val = cur_val;
        endcase

        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[Wr_addr] = new_val;
        end

        // Reads look at the post-edge array image, which gives write-first forwarding.
        rd_data_a_d = rd_data_a_q;
        zero_a_d    = zero_a_q;
        if (Rd_en_a) begin
            rd_data_a_d = rd_in_a ? regs_d[Rd_addr_a] : '0;
            zero_a_d    = (rd_data_a_d == '0);
        end

        rd_data_b_d = rd_data_b_q;
        zero_b_d    = zero_b_q;
        if (Rd_en_b) begin
            rd_data_b_d = rd_in_b ? regs_d[Rd_addr_b] : '0;
            zero_b_d    = (rd_data_b_d == '0);
        end

        addr_err_d = (Wr_en & ~wr_in) | (Rd_en_a & ~rd_in_a) | (Rd_en_b & ~rd_in_b);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            zero_a_q    <= 1'b1;
            zero_b_q    <= 1'b1;
            wrap_q      <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            zero_a_q    <= zero_a_d;
            zero_b_q    <= zero_b_d;
            wrap_q      <= wrap_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign Rd_data_a = rd_data_a_q;
    assign Rd_data_b = rd_data_b_q;
    assign Zero_a    = zero_a_q;
    assign Zero_b    = zero_b_q;
    assign Wrap      = wrap_q;
    assign Addr_err  = addr_err_q;

endmodule

// File: tb/tb_asip_reg_bank.sv
// Directed bench for asip_reg_bank. It uses three instances: the default 8x8, an
// 8-bit x 6 instance for address range errors, and a 16-bit x 16 instance.
module tb_asip_reg_bank;

    localparam logic [1:0] LD = 2'b00, INC = 2'b01, DEC = 2'b10, CLR = 2'b11;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    int chk = 0;
    int fails = 0;

    // Instance A: DATA_W=8, DEPTH=8
    logic       a_we = 0, a_rea = 0, a_reb = 0;
    logic [1:0] a_op = 0;
    logic [2:0] a_wa = 0, a_raa = 0, a_rab = 0;
    logic [7:0] a_wd = 0;
    logic [7:0] a_rda, a_rdb;
    logic       a_za, a_zb, a_wrap, a_err;

    asip_reg_bank #(.DATA_W(8), .DEPTH(8)) dut_a (
        .CLK(CLK), .RESET(RESET), .Wr_en(a_we), .Op(a_op), .Wr_addr(a_wa), .Wr_data(a_wd),
        .Rd_en_a(a_rea), .Rd_addr_a(a_raa), .Rd_en_b(a_reb), .Rd_addr_b(a_rab),
        .Rd_data_a(a_rda), .Rd_data_b(a_rdb), .Zero_a(a_za), .Zero_b(a_zb),
        .Wrap(a_wrap), .Addr_err(a_err)
    );

    // Instance B: DATA_W=8, DEPTH=6
    logic       b_we = 0, b_rea = 0, b_reb = 0;
    logic [1:0] b_op = 0;
    logic [2:0] b_wa = 0, b_raa = 0, b_rab = 0;
    logic [7:0] b_wd = 0;
    logic [7:0] b_rda, b_rdb;
    logic       b_za, b_zb, b_wrap, b_err;

    asip_reg_bank #(.DATA_W(8), .DEPTH(6)) dut_b (
        .CLK(CLK), .RESET(RESET), .Wr_en(b_we), .Op(b_op), .Wr_addr(b_wa), .Wr_data(b_wd),
        .Rd_en_a(b_rea), .Rd_addr_a(b_raa), .Rd_en_b(b_reb), .Rd_addr_b(b_rab),
        .Rd_data_a(b_rda), .Rd_data_b(b_rdb), .Zero_a(b_za), .Zero_b(b_zb),
        .Wrap(b_wrap), .Addr_err(b_err)
    );

    // Instance C: DATA_W=16, DEPTH=16
    logic        c_we = 0, c_rea = 0, c_reb = 0;
    logic [1:0]  c_op = 0;
    logic [3:0]  c_wa = 0, c_raa = 0, c_rab = 0;
    logic [15:0] c_wd = 0;
    logic [15:0] c_rda, c_rdb;
    logic        c_za, c_zb, c_wrap, c_err;

    asip_reg_bank #(.DATA_W(16), .DEPTH(16)) dut_c (
        .CLK(CLK), .RESET(RESET), .Wr_en(c_we), .Op(c_op), .Wr_addr(c_wa), .Wr_data(c_wd),
        .Rd_en_a(c_rea), .Rd_addr_a(c_raa), .Rd_en_b(c_reb), .Rd_addr_b(c_rab),
        .Rd_data_a(c_rda), .Rd_data_b(c_rdb), .Zero_a(c_za), .Zero_b(c_zb),
        .Wrap(c_wrap), .Addr_err(c_err)
    );

    // Apply one cycle of stimulus, then sample 1 time unit after the rising edge.
    task automatic a_cyc(input logic we, input logic [1:0] op, input logic [2:0] wa,
                         input logic [7:0] wd, input logic rea, input logic [2:0] ra,
                         input logic reb, input logic [2:0] rb);
        a_we = we; a_op = op; a_wa = wa; a_wd = wd;
        a_rea = rea; a_raa = ra; a_reb = reb; a_rab = rb;
        @(posedge CLK);
        #1;
    endtask

    task automatic b_cyc(input logic we, input logic [1:0] op, input logic [2:0] wa,
                         input logic [7:0] wd, input logic rea, input logic [2:0] ra,
                         input logic reb, input logic [2:0] rb);
        b_we = we; b_op = op; b_wa = wa; b_wd = wd;
        b_rea = rea; b_raa = ra; b_reb = reb; b_rab = rb;
        @(posedge CLK);
        #1;
    endtask

    task automatic c_cyc(input logic we, input logic [1:0] op, input logic [3:0] wa,
                         input logic [15:0] wd, input logic rea, input logic [3:0] ra,
                         input logic reb, input logic [3:0] rb);
        c_we = we; c_op = op; c_wa = wa; c_wd = wd;
        c_rea = rea; c_raa = ra; c_reb = reb; c_rab = rb;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge CLK);
        #1;
        chk++; if (a_rda !== 8'h00) begin fails++; $display("FAIL rst_rd_a: got %h exp 00", a_rda); end
        chk++; if (a_rdb !== 8'h00) begin fails++; $display("FAIL rst_rd_b: got %h exp 00", a_rdb); end
        chk++; if (a_za !== 1'b1 || a_zb !== 1'b1) begin fails++; $display("FAIL rst_zero: got %b%b exp 11", a_za, a_zb); end
        chk++; if (a_wrap !== 1'b0 || a_err !== 1'b0) begin fails++; $display("FAIL rst_flags: got wrap=%b err=%b exp 0 0", a_wrap, a_err); end
        RESET = 1'b1;

        a_cyc(1, LD, 3'd2, 8'h11, 0, 3'd0, 0, 3'd0);
        a_cyc(1, LD, 3'd7, 8'hFF, 0, 3'd0, 0, 3'd0);
        a_cyc(1, INC, 3'd7, 8'h00, 1, 3'd7, 1, 3'd2);
        chk++; if (a_rdb !== 8'h11 || a_wrap !== 1'b1) begin fails++; $display("FAIL pre_rst: got rd_b=%h wrap=%b exp 11 1", a_rdb, a_wrap); end

        // Reset between edges: outputs must clear without waiting for CLK.
        #1 RESET = 1'b0;
        #1;
        chk++; if (a_rdb !== 8'h00 || a_zb !== 1'b1) begin fails++; $display("FAIL async_rst_b: got %h z=%b exp 00 1", a_rdb, a_zb); end
        chk++; if (a_wrap !== 1'b0 || a_rda !== 8'h00 || a_za !== 1'b1) begin fails++; $display("FAIL async_rst_a: got rd=%h z=%b wrap=%b exp 00 1 0", a_rda, a_za, a_wrap); end

        a_we = 1; a_op = LD; a_wa = 3'd4; a_wd = 8'h77; a_rea = 0; a_reb = 0;
        @(posedge CLK);
        #1;
        a_we = 0;
        RESET = 1'b1;

        for (int i = 0; i < 4; i++) begin
            a_cyc(0, LD, 3'd0, 8'h00, 1, 3'(i), 1, 3'(i + 4));
            chk++; if (a_rda !== 8'h00 || a_za !== 1'b1) begin fails++; $display("FAIL rst_scan_a R%0d: got %h z=%b exp 00 1", i, a_rda, a_za); end
            chk++; if (a_rdb !== 8'h00 || a_zb !== 1'b1) begin fails++; $display("FAIL rst_scan_b R%0d: got %h z=%b exp 00 1", i + 4, a_rdb, a_zb); end
        end
    endtask

    task automatic test_load_forward;
        a_cyc(1, LD, 3'd3, 8'hA5, 0, 3'd0, 0, 3'd0);
        a_cyc(1, LD, 3'd5, 8'h3C, 1, 3'd3, 1, 3'd5);
        chk++; if (a_rda !== 8'hA5 || a_za !== 1'b0) begin fails++; $display("FAIL ld_rd_a: got %h z=%b exp a5 0", a_rda, a_za); end
        chk++; if (a_rdb !== 8'h3C || a_zb !== 1'b0) begin fails++; $display("FAIL fwd_rd_b: got %h z=%b exp 3c 0", a_rdb, a_zb); end
        chk++; if (a_wrap !== 1'b0 || a_err !== 1'b0) begin fails++; $display("FAIL ld_flags: got wrap=%b err=%b exp 0 0", a_wrap, a_err); end
    endtask

    task automatic test_inc_wrap;
        a_cyc(1, LD, 3'd1, 8'hFE, 0, 3'd0, 0, 3'd0);
        a_cyc(1, INC, 3'd1, 8'h00, 1, 3'd1, 0, 3'd0);
        chk++; if (a_rda !== 8'hFF || a_wrap !== 1'b0) begin fails++; $display("FAIL inc1: got %h wrap=%b exp ff 0", a_rda, a_wrap); end
        a_cyc(1, INC, 3'd1, 8'h00, 1, 3'd1, 0, 3'd0);
        chk++; if (a_rda !== 8'h00 || a_wrap !== 1'b1 || a_za !== 1'b1) begin fails++; $display("FAIL inc_wrap: got %h wrap=%b z=%b exp 00 1 1", a_rda, a_wrap, a_za); end
        a_cyc(0, LD, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0);
        chk++; if (a_wrap !== 1'b0 || a_rda !== 8'h00) begin fails++; $display("FAIL wrap_pulse: got wrap=%b rd=%h exp 0 00", a_wrap, a_rda); end
    endtask

    task automatic test_dec_clear;
        a_cyc(1, LD, 3'd2, 8'h00, 0, 3'd0, 0, 3'd0);
        a_cyc(1, DEC, 3'd2, 8'h00, 1, 3'd2, 0, 3'd0);
        chk++; if (a_rda !== 8'hFF || a_wrap !== 1'b1 || a_za !== 1'b0) begin fails++; $display("FAIL dec_wrap: got %h wrap=%b z=%b exp ff 1 0", a_rda, a_wrap, a_za); end
        a_cyc(1, CLR, 3'd2, 8'h99, 1, 3'd2, 1, 3'd2);
        chk++; if (a_rda !== 8'h00 || a_rdb !== 8'h00) begin fails++; $display("FAIL clr_both: got %h %h exp 00 00", a_rda, a_rdb); end
        chk++; if (a_za !== 1'b1 || a_zb !== 1'b1 || a_wrap !== 1'b0) begin fails++; $display("FAIL clr_flags: got za=%b zb=%b wrap=%b exp 1 1 0", a_za, a_zb, a_wrap); end
    endtask

    task automatic test_back_to_back;
        a_cyc(1, LD, 3'd6, 8'h40, 0, 3'd0, 0, 3'd0);
        for (int i = 1; i <= 3; i++) begin
            a_cyc(1, INC, 3'd6, 8'h00, 1, 3'd6, 0, 3'd0);
            chk++; if (a_rda !== 8'(8'h40 + i)) begin fails++; $display("FAIL b2b_inc %0d: got %h exp %h", i, a_rda, 8'(8'h40 + i)); end
        end
    endtask

    task automatic test_hold;
        a_cyc(1, LD, 3'd0, 8'h12, 1, 3'd0, 0, 3'd0);
        chk++; if (a_rda !== 8'h12) begin fails++; $display("FAIL hold_setup: got %h exp 12", a_rda); end
        a_cyc(1, LD, 3'd0, 8'h34, 0, 3'd0, 1, 3'd0);
        chk++; if (a_rda !== 8'h12 || a_za !== 1'b0) begin fails++; $display("FAIL hold_a: got %h z=%b exp 12 0", a_rda, a_za); end
        chk++; if (a_rdb !== 8'h34) begin fails++; $display("FAIL hold_b: got %h exp 34", a_rdb); end
        a_cyc(0, LD, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0);
    endtask

    task automatic test_out_of_range;
        for (int i = 0; i < 6; i++) begin
            b_cyc(1, LD, 3'(i), 8'(8'h10 + i), 0, 3'd0, 0, 3'd0);
        end
        b_cyc(1, LD, 3'd7, 8'h55, 1, 3'd5, 0, 3'd0);
        chk++; if (b_rda !== 8'h15 || b_err !== 1'b1 || b_wrap !== 1'b0) begin fails++; $display("FAIL oor_wr: got rd=%h err=%b wrap=%b exp 15 1 0", b_rda, b_err, b_wrap); end
        b_cyc(0, LD, 3'd0, 8'h00, 0, 3'd0, 0, 3'd0);
        chk++; if (b_err !== 1'b0) begin fails++; $display("FAIL oor_pulse: got err=%b exp 0", b_err); end
        b_cyc(0, LD, 3'd0, 8'h00, 1, 3'd6, 0, 3'd0);
        chk++; if (b_rda !== 8'h00 || b_za !== 1'b1 || b_err !== 1'b1) begin fails++; $display("FAIL oor_rd: got %h z=%b err=%b exp 00 1 1", b_rda, b_za, b_err); end
        b_cyc(1, INC, 3'd6, 8'h00, 0, 3'd0, 0, 3'd0);
        chk++; if (b_wrap !== 1'b0 || b_err !== 1'b1) begin fails++; $display("FAIL oor_inc: got wrap=%b err=%b exp 0 1", b_wrap, b_err); end
        for (int i = 0; i < 3; i++) begin
            b_cyc(0, LD, 3'd0, 8'h00, 1, 3'(i), 1, 3'(i + 3));
            chk++; if (b_rda !== 8'(8'h10 + i)) begin fails++; $display("FAIL oor_scan_a R%0d: got %h exp %h", i, b_rda, 8'(8'h10 + i)); end
            chk++; if (b_rdb !== 8'(8'h13 + i)) begin fails++; $display("FAIL oor_scan_b R%0d: got %h exp %h", i + 3, b_rdb, 8'(8'h13 + i)); end
        end
        chk++; if (b_err !== 1'b0) begin fails++; $display("FAIL oor_clear: got err=%b exp 0", b_err); end
    endtask

    task automatic test_wide;
        c_cyc(1, LD, 4'd9, 16'hFFFF, 0, 4'd0, 0, 4'd0);
        c_cyc(1, INC, 4'd9, 16'h0000, 1, 4'd9, 0, 4'd0);
        chk++; if (c_rda !== 16'h0000 || c_wrap !== 1'b1 || c_za !== 1'b1) begin fails++; $display("FAIL w16_inc: got %h wrap=%b z=%b exp 0000 1 1", c_rda, c_wrap, c_za); end
        c_cyc(1, DEC, 4'd9, 16'h0000, 0, 4'd0, 1, 4'd9);
        chk++; if (c_rdb !== 16'hFFFF || c_wrap !== 1'b1 || c_zb !== 1'b0) begin fails++; $display("FAIL w16_dec: got %h wrap=%b z=%b exp ffff 1 0", c_rdb, c_wrap, c_zb); end
        c_cyc(1, LD, 4'd15, 16'h1234, 1, 4'd15, 0, 4'd0);
        chk++; if (c_rda !== 16'h1234 || c_wrap !== 1'b0 || c_err !== 1'b0) begin fails++; $display("FAIL w16_ld: got %h wrap=%b err=%b exp 1234 0 0", c_rda, c_wrap, c_err); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_load_forward();
        test_inc_wrap();
        test_dec_clear();
        test_back_to_back();
        test_hold();
        test_out_of_range();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", chk, fails);
        $finish;
    end

endmodule
